yuv420_capture_ctrl: RTL and testbench
======================================

// Module: yuv420_capture_ctrl
// PURPOSE
//  Frame-capture sequencer placed in front of the yuv420 packer. It holds the packer's
//  image_type/enable constant for a whole capture run and forwards only whole frames
//  (with optional frame decimation). It also monitors the packer output so it can
//  report completion, per-frame word counts and errors to the host register file.
// PARAMETERS
//  DRAIN_TIMEOUT  4096  cycles allowed in DRAIN before err_timeout and forced return to IDLE
//  WCNT_WIDTH     24    width of the packer-output word counters
// PORTS
//  clk            in   1    system clock
//  resetb         in   1    asynchronous active-low reset
//  cfg_image_type in   16   requested image_type (0=raw), sampled on accepted start
//  cfg_enable     in   1    requested 420 subsampling enable, sampled on accepted start
//  cfg_num_frames in   16   frames to capture; 0 = continuous until stop
//  cfg_skip       in   8    frames dropped between captured frames (decimation N+1)
//  start          in   1    single-cycle capture request
//  stop           in   1    single-cycle stop request
//  dvi/dtypei     in   1/`DTYPE_WIDTH   imager stream beat
//  meta_datai     in   16   header/raw data
//  yi/ui/vi       in   8 each  pixel components
//  dvo/dtypeo/meta_datao/yo/uo/vo  out  same widths  gated stream to packer
//  image_type     out  16   shadowed to packer
//  enable         out  1    shadowed to packer
//  pk_dvi/pk_dtypei  in 1/`DTYPE_WIDTH  packer output monitor
//  busy           out  1    state != IDLE
//  done           out  1    one-cycle pulse on DRAIN->IDLE
//  frames_sent    out  16   frames forwarded in the current/last run
//  words_last     out  WCNT_WIDTH  packer pixel words in last completed output frame
//  err_sync       out  1    sticky: FRAME_START seen while in PASS
//  err_timeout    out  1    sticky: DRAIN timed out
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and counters 0; err flags cleared. Only reset clears err_*.
//  Stream path is registered, 1-cycle latency; dvo=dvi & gate; other fields always copied.
//  States:
//  - IDLE: gate=0. start&!stop -> latch shadow image_type/enable, frames_sent=0,
//    pk_frames=0, skip_cnt=0 -> WAIT_SOF. start&stop together -> stay IDLE.
//  - WAIT_SOF: gate=0 except on the FRAME_START beat.
//    dvi&FRAME_START with skip_cnt==0 -> forward the beat and go to PASS.
//    dvi&FRAME_START with skip_cnt!=0 -> drop the beat and go to SKIP.
//  - SKIP: gate=0. dvi&FRAME_END -> skip_cnt-1 -> WAIT_SOF.
//  - PASS: gate=1. On dvi&FRAME_END (forwarded): frames_sent+1, skip_cnt=cfg_skip.
//    Then -> DRAIN if stop_req or (cfg_num_frames!=0 and frames_sent+1==cfg_num_frames);
//    else -> WAIT_SOF.
//  - DRAIN: gate=0. -> IDLE with done=1 when pk_frames==frames_sent, or when the
//    timeout counter reaches DRAIN_TIMEOUT (set err_timeout).
//  stop in WAIT_SOF/SKIP -> DRAIN immediately. stop in PASS sets stop_req and lets the
//    current frame finish. stop_req clears on entry to IDLE.
//  FRAME_START received while in PASS: set err_sync, forward it, stay in PASS,
//    frames_sent unchanged.
//  Shadow image_type/enable change only in IDLE on an accepted start; cfg_* changes
//    mid-run are ignored. cfg_num_frames and cfg_skip are also sampled at start.
//  Monitor: wcnt increments on pk_dvi with a pixel-mask dtype. pk_dvi&FRAME_END:
//    words_last=wcnt, wcnt=0, pk_frames+1. pk_dvi&FRAME_START: wcnt=0.
//  Counters saturate (no wrap). Continuous mode: frames_sent saturates at 16'hFFFF.
//  Async reset mid-frame returns immediately to IDLE. The downstream packer must be
//    reset with it.
// TESTING
//  1. Start num=2, skip=0, 3 frames of 4x2 pixels -> frames 1,2 forwarded, 3 dropped;
//     done 1 cycle after 2nd packer FRAME_END.
//  2. Start asserted mid-frame -> nothing forwarded until next FRAME_START; dvo lags
//     dvi by exactly 1 cycle.
//  3. skip=2, num=2, 6 input frames -> input frames 1 and 4 forwarded; frames_sent=2.
//  4. type=1, enable=1, 4x2 frame -> words_last=3 (12 bytes: 8 Y + 2x(U,V)).
//  5. num=0; stop mid-frame 3 -> frame 3 completes; frames_sent=3, done pulses.
//  6. Hold pk_dvi=0 in DRAIN -> err_timeout at DRAIN_TIMEOUT, IDLE. Change cfg during
//     PASS -> image_type unchanged.

Source files
------------

// File: rtl/yuv420_capture_ctrl.sv
// Frame-capture sequencer in front of the yuv420 packer: gates whole frames with optional
// decimation, shadows packer config per run, and monitors packer output for completion/errors.
module yuv420_capture_ctrl #(
  parameter int                     DRAIN_TIMEOUT  = 4096,
  parameter int                     WCNT_WIDTH     = 24,
  parameter int                     DTYPE_WIDTH    = 8,
  parameter logic [DTYPE_WIDTH-1:0] DT_FRAME_START = DTYPE_WIDTH'(8'h01),
  parameter logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = DTYPE_WIDTH'(8'h02),
  parameter logic [DTYPE_WIDTH-1:0] DT_PIXEL_MASK  = DTYPE_WIDTH'(8'h40)
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic [15:0]            cfg_image_type,
  input  logic                   cfg_enable,
  input  logic [15:0]            cfg_num_frames,
  input  logic [7:0]             cfg_skip,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [15:0]            meta_datai,
  input  logic [7:0]             yi,
  input  logic [7:0]             ui,
  input  logic [7:0]             vi,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]            meta_datao,
  output logic [7:0]             yo,
  output logic [7:0]             uo,
  output logic [7:0]             vo,
  output logic [15:0]            image_type,
  output logic                   enable,
  input  logic                   pk_dvi,
  input  logic [DTYPE_WIDTH-1:0] pk_dtypei,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            frames_sent,
  output logic [WCNT_WIDTH-1:0]  words_last,
  output logic                   err_sync,
  output logic                   err_timeout
);

  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_SOF, SKIP, PASS, DRAIN} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [WCNT_WIDTH-1:0] sat_inc_w(input logic [WCNT_WIDTH-1:0] v);
    return (&v) ? v : v + WCNT_WIDTH'(1);
  endfunction

  state_t                state, state_nxt;
  logic [15:0]           num_q;
  logic [7:0]            skip_q;
  logic [7:0]            skip_cnt;
  logic                  stop_req;
  logic [15:0]           pk_frames;
  logic [WCNT_WIDTH-1:0] wcnt;
  logic [TO_W-1:0]       tcnt;

  logic gate, accept, fe_pass, skip_dec, sync_hit, drain_ok, drain_to;
  logic in_fs, in_fe, pk_fs, pk_fe, pk_px, last_frame;

  assign in_fs = dvi && (dtypei == DT_FRAME_START);
  assign in_fe = dvi && (dtypei == DT_FRAME_END);
  assign pk_fs = pk_dvi && (pk_dtypei == DT_FRAME_START);
  assign pk_fe = pk_dvi && (pk_dtypei == DT_FRAME_END);
  assign pk_px = pk_dvi && ((pk_dtypei & DT_PIXEL_MASK) != '0);
  assign last_frame = (num_q != 16'd0) && (sat_inc16(frames_sent) == num_q);
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    gate      = 1'b0;
    accept    = 1'b0;
    fe_pass   = 1'b0;
    skip_dec  = 1'b0;
    sync_hit  = 1'b0;
    drain_ok  = 1'b0;
    drain_to  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          accept    = 1'b1;
          state_nxt = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        if (stop) begin
          state_nxt = DRAIN;
        end else if (in_fs) begin
          if (skip_cnt == 8'd0) begin
            gate      = 1'b1;
            state_nxt = PASS;
          end else begin
            state_nxt = SKIP;
          end
        end
      end
      SKIP: begin
        if (stop) begin
          state_nxt = DRAIN;
        end else if (in_fe) begin
          skip_dec  = 1'b1;
          state_nxt = WAIT_SOF;
        end
      end
      PASS: begin
        gate     = 1'b1;
        sync_hit = in_fs;
        if (in_fe) begin
          fe_pass   = 1'b1;
          // a stop arriving on the FRAME_END beat itself still ends the run here
          state_nxt = (stop_req || stop || last_frame) ? DRAIN : WAIT_SOF;
        end
      end
      DRAIN: begin
        if (pk_frames == frames_sent) begin
          drain_ok  = 1'b1;
          state_nxt = IDLE;
        end else if (tcnt == TO_W'(DRAIN_TIMEOUT - 1)) begin
          drain_to  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // control stage: state, shadow config, run counters, sticky errors
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      done        <= 1'b0;
      image_type  <= '0;
      enable      <= 1'b0;
      num_q       <= '0;
      skip_q      <= '0;
      skip_cnt    <= '0;
      frames_sent <= '0;
      stop_req    <= 1'b0;
      err_sync    <= 1'b0;
      err_timeout <= 1'b0;
      tcnt        <= '0;
    end else begin
      state <= state_nxt;
      done  <= drain_ok | drain_to;
      if (accept) begin
        image_type  <= cfg_image_type;
        enable      <= cfg_enable;
        num_q       <= cfg_num_frames;
        skip_q      <= cfg_skip;
        skip_cnt    <= '0;
        frames_sent <= '0;
      end else if (fe_pass) begin
        frames_sent <= sat_inc16(frames_sent);
        skip_cnt    <= skip_q;
      end else if (skip_dec && (skip_cnt != 8'd0)) begin
        skip_cnt <= skip_cnt - 8'd1;
      end
      if (state_nxt == IDLE) stop_req <= 1'b0;
      else if ((state == PASS) && stop) stop_req <= 1'b1;
      if (sync_hit) err_sync <= 1'b1;
      if (drain_to) err_timeout <= 1'b1;
      tcnt <= (state == DRAIN) ? tcnt + TO_W'(1) : '0;
    end
  end

  // stream stage: one-cycle registered copy, valid gated by the sequencer
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dvo        <= 1'b0;
      dtypeo     <= '0;
      meta_datao <= '0;
      yo         <= '0;
      uo         <= '0;
      vo         <= '0;
    end else begin
      dvo        <= dvi & gate;
      dtypeo     <= dtypei;
      meta_datao <= meta_datai;
      yo         <= yi;
      uo         <= ui;
      vo         <= vi;
    end
  end

  // monitor stage: packer output word and frame counting
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pk_frames  <= '0;
      wcnt       <= '0;
      words_last <= '0;
    end else begin
      if (pk_fe) begin
        words_last <= wcnt;
        wcnt       <= '0;
      end else if (pk_fs) begin
        wcnt <= '0;
      end else if (pk_px) begin
        wcnt <= sat_inc_w(wcnt);
      end
      if (accept) pk_frames <= '0;
      else if (pk_fe) pk_frames <= sat_inc16(pk_frames);
    end
  end

endmodule

// File: tb/tb_yuv420_capture_ctrl.sv
// Scoreboard bench for yuv420_capture_ctrl: forwarded beats are queued at drive time and
// popped when dvo fires; packer output is looped back or hand-driven.
module tb_yuv420_capture_ctrl;
  localparam int         TO    = 64;
  localparam logic [7:0] DT_FS = 8'h01;
  localparam logic [7:0] DT_FE = 8'h02;
  localparam logic [7:0] DT_PX = 8'h41;

  logic        clk = 1'b0;
  logic        resetb;
  logic [15:0] cfg_image_type, cfg_num_frames;
  logic        cfg_enable;
  logic [7:0]  cfg_skip;
  logic        start, stop, dvi;
  logic [7:0]  dtypei, yi, ui, vi;
  logic [15:0] meta_datai;
  logic        dvo;
  logic [7:0]  dtypeo, yo, uo, vo;
  logic [15:0] meta_datao, image_type, frames_sent;
  logic        enable, pk_dvi, busy, done, err_sync, err_timeout;
  logic [7:0]  pk_dtypei;
  logic [23:0] words_last;

  logic       loop_en, lp_dv, man_dv;
  logic [7:0] lp_dt, man_dt;
  assign pk_dvi    = loop_en ? lp_dv : man_dv;
  assign pk_dtypei = loop_en ? lp_dt : man_dt;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, pk_fe_cyc = 0, d0 = 0;
  logic done_prev = 1'b0;
  logic [47:0] exp_q[$];
  int          exp_cyc_q[$];

  yuv420_capture_ctrl #(.DRAIN_TIMEOUT(TO), .WCNT_WIDTH(24), .DTYPE_WIDTH(8),
    .DT_FRAME_START(DT_FS), .DT_FRAME_END(DT_FE), .DT_PIXEL_MASK(8'h40)) dut (
    .clk(clk), .resetb(resetb), .cfg_image_type(cfg_image_type), .cfg_enable(cfg_enable),
    .cfg_num_frames(cfg_num_frames), .cfg_skip(cfg_skip), .start(start), .stop(stop),
    .dvi(dvi), .dtypei(dtypei), .meta_datai(meta_datai), .yi(yi), .ui(ui), .vi(vi),
    .dvo(dvo), .dtypeo(dtypeo), .meta_datao(meta_datao), .yo(yo), .uo(uo), .vo(vo),
    .image_type(image_type), .enable(enable), .pk_dvi(pk_dvi), .pk_dtypei(pk_dtypei),
    .busy(busy), .done(done), .frames_sent(frames_sent), .words_last(words_last),
    .err_sync(err_sync), .err_timeout(err_timeout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard pop on every forwarded beat
  always @(negedge clk) begin
    if (resetb && dvo) begin
      if (exp_q.size() == 0) chk("dvo_unexpected", 64'(exp_q.size()), 64'd1);
      else begin
        chk("dvo_beat", {dtypeo, meta_datao, yo, uo, vo}, exp_q.pop_front());
        chk("dvo_latency", 64'(cyc - exp_cyc_q.pop_front()), 64'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (done) begin
      chk("done_width", done_prev, 1'b0);
      done_cnt++;
      done_cyc = cyc;
    end
    done_prev = done;
  end

  // packer stand-in: echoes every forwarded beat one cycle later
  always @(negedge clk) begin
    lp_dv = dvo;
    lp_dt = dtypeo;
    if (loop_en && dvo && dtypeo == DT_FE) pk_fe_cyc = cyc + 1;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dvi = 1'b0; start = 1'b0; stop = 1'b0;
    end
  endtask

  task automatic drive_beat(input logic [7:0] dt, input bit push, input bit do_start,
                            input bit do_stop);
    @(negedge clk);
    dvi = 1'b1; dtypei = dt; start = do_start; stop = do_stop;
    meta_datai = 16'($urandom); yi = 8'($urandom); ui = 8'($urandom); vi = 8'($urandom);
    if (push) begin
      exp_q.push_back({dt, meta_datai, yi, ui, vi});
      exp_cyc_q.push_back(cyc);
    end
  endtask

  // 4x2 frame: FRAME_START, 8 pixel beats, FRAME_END (index 0..9)
  task automatic send_frame(input bit fwd, input int start_at, input int stop_at,
                            input int fs_at);
    logic [7:0] dt;
    for (int i = 0; i < 10; i++) begin
      dt = (i == 0 || i == fs_at) ? DT_FS : (i == 9) ? DT_FE : DT_PX;
      drive_beat(dt, fwd, i == start_at, i == stop_at);
    end
  endtask

  task automatic pulse_start(input logic [15:0] num, input logic [7:0] skp,
                             input logic [15:0] typ, input logic en);
    @(negedge clk);
    cfg_num_frames = num; cfg_skip = skp; cfg_image_type = typ; cfg_enable = en;
    dvi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk({tag, "_idle_timeout"}, busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic pk_beat(input logic [7:0] dt);
    @(negedge clk);
    man_dv = 1'b1; man_dt = dt;
  endtask

  initial begin
    resetb = 1'b0; start = 1'b0; stop = 1'b0; dvi = 1'b0; dtypei = '0; meta_datai = '0;
    yi = '0; ui = '0; vi = '0; cfg_image_type = '0; cfg_enable = 1'b0;
    cfg_num_frames = '0; cfg_skip = '0; loop_en = 1'b1; man_dv = 1'b0; man_dt = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_dvo", dvo, 0);
    chk("rst_frames", frames_sent, 0); chk("rst_words", words_last, 0);
    chk("rst_errs", {err_sync, err_timeout}, 0); chk("rst_type", {image_type, enable}, 0);
    resetb = 1'b1;
    idle(2);

    @(negedge clk);
    cfg_num_frames = 16'd1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", busy, 0);

    // num=2: frames 1,2 forwarded, frame 3 dropped
    d0 = done_cnt;
    pulse_start(16'd2, 8'd0, 16'd0, 1'b0);
    send_frame(1, -1, -1, -1); send_frame(1, -1, -1, -1); send_frame(0, -1, -1, -1);
    idle(1);
    wait_idle("t1", 200);
    chk("t1_frames", frames_sent, 2); chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_done_lat", 64'(done_cyc - pk_fe_cyc), 1); chk("t1_words", words_last, 8);
    chk("t1_q_empty", exp_q.size(), 0);

    // start arrives mid-frame: only the following frame passes
    d0 = done_cnt;
    cfg_num_frames = 16'd1; cfg_skip = 8'd0;
    send_frame(0, 4, -1, -1); send_frame(1, -1, -1, -1);
    idle(1);
    wait_idle("t2", 200);
    chk("t2_frames", frames_sent, 1); chk("t2_done_cnt", done_cnt - d0, 1);
    chk("t2_q_empty", exp_q.size(), 0);

    // skip=2, num=2: input frames 1 and 4 forwarded
    pulse_start(16'd2, 8'd2, 16'd0, 1'b0);
    for (int i = 0; i < 6; i++) send_frame(i == 0 || i == 3, -1, -1, -1);
    idle(1);
    wait_idle("t3", 200);
    chk("t3_frames", frames_sent, 2); chk("t3_q_empty", exp_q.size(), 0);

    // hand-driven packer output of 3 words for a 420 frame
    loop_en = 1'b0;
    d0 = done_cnt;
    pulse_start(16'd1, 8'd0, 16'd1, 1'b1);
    send_frame(1, -1, -1, -1);
    idle(3);
    chk("t4_drain_wait", busy, 1);
    pk_beat(DT_FS); pk_beat(DT_PX); pk_beat(DT_PX); pk_beat(DT_PX); pk_beat(DT_FE);
    @(negedge clk); man_dv = 1'b0;
    wait_idle("t4", 50);
    chk("t4_words", words_last, 3); chk("t4_type", {image_type, enable}, {16'd1, 1'b1});
    chk("t4_done_cnt", done_cnt - d0, 1);
    loop_en = 1'b1;

    // continuous mode, stop mid frame 3
    d0 = done_cnt;
    pulse_start(16'd0, 8'd0, 16'd2, 1'b0);
    send_frame(1, -1, -1, -1); send_frame(1, -1, -1, -1); send_frame(1, -1, 4, -1);
    idle(1);
    wait_idle("t5", 200);
    chk("t5_frames", frames_sent, 3); chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_words", words_last, 8); chk("t5_q_empty", exp_q.size(), 0);

    // stray FRAME_START inside a passing frame
    pulse_start(16'd1, 8'd0, 16'd3, 1'b0);
    send_frame(1, -1, -1, 3);
    idle(1);
    wait_idle("sync", 200);
    chk("sync_err", err_sync, 1); chk("sync_frames", frames_sent, 1);
    chk("sync_words", words_last, 5); chk("sync_no_to", err_timeout, 0);

    // silent packer: drain times out; cfg changed mid-frame is ignored
    loop_en = 1'b0;
    d0 = done_cnt;
    pulse_start(16'd1, 8'd0, 16'd5, 1'b0);
    drive_beat(DT_FS, 1, 0, 0);
    cfg_image_type = 16'd9; cfg_enable = 1'b1; cfg_num_frames = 16'd7;
    for (int i = 0; i < 8; i++) drive_beat(DT_PX, 1, 0, 0);
    drive_beat(DT_FE, 1, 0, 0);
    idle(1);
    chk("t6_type_hold", {image_type, enable}, {16'd5, 1'b0});
    idle(TO - 8);
    chk("t6_no_early_to", err_timeout, 0); chk("t6_still_drain", busy, 1);
    wait_idle("t6", TO + 16);
    chk("t6_err_to", err_timeout, 1); chk("t6_done_cnt", done_cnt - d0, 1);
    chk("t6_frames", frames_sent, 1); chk("t6_sync_sticky", err_sync, 1);
    chk("t6_type_end", image_type, 16'd5); chk("t6_q_empty", exp_q.size(), 0);

    // asynchronous reset mid-run
    pulse_start(16'd1, 8'd0, 16'd7, 1'b1);
    chk("ar_busy_before", busy, 1);
    #2 resetb = 1'b0;
    #1;
    chk("ar_busy", busy, 0); chk("ar_errs", {err_sync, err_timeout}, 0);
    chk("ar_type", image_type, 0);
    idle(2);
    resetb = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
